// File: rtl/gate_sweep_engine_if.sv
// Stimulus/result bundle between gate_sweep_engine and its consumer.
// With GATE_CHECK_EN defined the bundle also carries the DUT-output check signals.
interface gate_sweep_engine_if #(
  parameter int N_IN = 2
);
  logic            start;
  logic [1:0]      mode;
  logic [N_IN-1:0] vec;
  logic            vec_valid;
  logic            exp;
  logic            busy;
  logic            done;
  logic [N_IN:0]   ones_cnt;
`ifdef GATE_CHECK_EN
  logic            dut_out;
  logic [N_IN:0]   mism_cnt;
  logic            pass;
`endif

  modport master (
    input  start, mode,
`ifdef GATE_CHECK_EN
    input  dut_out,
    output mism_cnt, pass,
`endif
    output vec, vec_valid, exp, busy, done, ones_cnt
  );

  modport slave (
    output start, mode,
`ifdef GATE_CHECK_EN
    output dut_out,
    input  mism_cnt, pass,
`endif
    input  vec, vec_valid, exp, busy, done, ones_cnt
  );
endinterface

// File: rtl/gate_sweep_engine.sv
// Truth-table sweeper: walks all 2**N_IN input vectors with a registered expected gate output.
// Optional macro GATE_CHECK_EN adds DUT-output comparison (mism_cnt, pass).
module gate_sweep_engine #(
  parameter int N_IN        = 2,
  parameter int HOLD_CYCLES = 5
) (
  input  logic                clk,
  input  logic                rst,
  gate_sweep_engine_if.master bus
);
  localparam int            HW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
  localparam logic [N_IN:0] LAST_VEC = (N_IN+1)'((2 ** N_IN) - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [N_IN:0]   r_vec;
  logic [HW-1:0]   r_hold;
  logic [1:0]      r_mode;
  logic            r_exp;
  logic [N_IN:0]   r_ones;
  logic            w_accept;
  logic            w_last_hold;
  logic            w_end;
  logic [N_IN:0]   w_vec_inc;

  function automatic logic gate_eval(input logic [1:0] m, input logic [N_IN-1:0] v);
    case (m)
      2'b00:   return &v;
      2'b01:   return |v;
      2'b10:   return ^v;
      default: return ~&v;
    endcase
  endfunction

  assign w_vec_inc = r_vec + (N_IN+1)'(1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_last_hold = 1'b0;
    w_end       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (r_hold == HOLD_MAX) begin
          w_last_hold = 1'b1;
          if (r_vec == LAST_VEC) begin
            w_end  = 1'b1;
            w_next = S_DONE;
          end
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Vector / expected-output stage: exp is updated on the same edge as vec.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec  <= '0;
      r_hold <= '0;
      r_mode <= '0;
      r_exp  <= 1'b0;
      r_ones <= '0;
    end else if (w_accept) begin
      r_mode <= bus.mode;
      r_vec  <= '0;
      r_hold <= '0;
      r_ones <= '0;
      r_exp  <= gate_eval(bus.mode, '0);
    end else if (r_state == S_DRIVE) begin
      if (w_last_hold) begin
        r_hold <= '0;
        if (r_exp) r_ones <= r_ones + (N_IN+1)'(1);
        if (!w_end) begin
          r_vec <= w_vec_inc;
          r_exp <= gate_eval(r_mode, w_vec_inc[N_IN-1:0]);
        end
      end else begin
        r_hold <= r_hold + HW'(1);
      end
    end
  end

  assign bus.vec       = r_vec[N_IN-1:0];
  assign bus.exp       = r_exp;
  assign bus.ones_cnt  = r_ones;
  assign bus.vec_valid = (r_state == S_DRIVE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);

`ifdef GATE_CHECK_EN
  logic [N_IN:0] r_mism;
  logic          r_pass;
  logic          w_miss;
  logic [N_IN:0] w_mism_next;

  assign w_miss      = w_last_hold && (bus.dut_out != r_exp);
  assign w_mism_next = r_mism + (N_IN+1)'(w_miss);

  // Check stage: the final vector's compare is folded into pass on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mism <= '0;
      r_pass <= 1'b0;
    end else if (w_accept) begin
      r_mism <= '0;
      r_pass <= 1'b0;
    end else if (w_last_hold) begin
      r_mism <= w_mism_next;
      if (w_end) r_pass <= (w_mism_next == '0);
    end
  end

  assign bus.mism_cnt = r_mism;
  assign bus.pass     = r_pass;
`endif
endmodule

// File: tb/tb_gate_sweep_engine.sv
// Directed bench for gate_sweep_engine: table-driven mode sweeps plus reset, mid-sweep and back-to-back cases.
module tb_gate_sweep_engine;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gate_sweep_engine_if #(.N_IN(2)) bus ();
  gate_sweep_engine_if #(.N_IN(3)) bus3 ();

  gate_sweep_engine #(.N_IN(2), .HOLD_CYCLES(5)) dut  (.clk(clk), .rst(rst), .bus(bus));
  gate_sweep_engine #(.N_IN(3), .HOLD_CYCLES(1)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int checks = 0;
  int errors = 0;

`ifdef GATE_CHECK_EN
  logic dut_is_or = 1'b0;
  assign bus.dut_out  = dut_is_or ? (|bus.vec) : (&bus.vec);
  assign bus3.dut_out = 1'b0;
`endif

  typedef struct {
    logic [1:0] mode;
    logic [3:0] exp_bits;
    int         ones;
  } sweep_vec_t;

  sweep_vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Runs one N_IN=2 sweep, checking every cycle; inject=1 pokes start/mode=01 while vec=2.
  task automatic sweep(input logic [1:0] m, input logic [3:0] eb, input int ones, input bit inject);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = m;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (inject && c == 10) begin
        bus.start = 1'b1;
        bus.mode  = 2'b01;
      end
      if (inject && c == 12) bus.start = 1'b0;
      chk("vec", 32'(bus.vec), 32'(c / 5));
      chk("exp", 32'(bus.exp), 32'(eb[c / 5]));
      chk("vec_valid", 32'(bus.vec_valid), 1);
      chk("busy", 32'(bus.busy), 1);
      chk("done_low", 32'(bus.done), 0);
      @(negedge clk);
    end
    chk("done_pulse", 32'(bus.done), 1);
    chk("done_busy", 32'(bus.busy), 1);
    chk("done_vec_valid", 32'(bus.vec_valid), 0);
    chk("done_vec", 32'(bus.vec), 3);
    chk("ones_cnt", 32'(bus.ones_cnt), 32'(ones));
    @(negedge clk);
    chk("idle_done", 32'(bus.done), 0);
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_vec_hold", 32'(bus.vec), 3);
    chk("idle_ones_hold", 32'(bus.ones_cnt), 32'(ones));
  endtask

  initial begin
    int ndone;
    logic [7:0] par;
    tbl[0] = '{mode: 2'b00, exp_bits: 4'b1000, ones: 1};
    tbl[1] = '{mode: 2'b01, exp_bits: 4'b1110, ones: 3};
    tbl[2] = '{mode: 2'b10, exp_bits: 4'b0110, ones: 2};
    tbl[3] = '{mode: 2'b11, exp_bits: 4'b0111, ones: 3};

    rst = 1'b1;
    bus.start = 1'b0;  bus.mode = 2'b00;
    bus3.start = 1'b0; bus3.mode = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vec", 32'(bus.vec), 0);
    chk("rst_vec_valid", 32'(bus.vec_valid), 0);
    chk("rst_exp", 32'(bus.exp), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_ones", 32'(bus.ones_cnt), 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) sweep(tbl[i].mode, tbl[i].exp_bits, tbl[i].ones, 1'b0);

`ifdef GATE_CHECK_EN
    chk("pass_after_nand", 32'(bus.pass), 0);
    dut_is_or = 1'b0;
    sweep(2'b00, 4'b1000, 1, 1'b0);
    chk("mism_good", 32'(bus.mism_cnt), 0);
    chk("pass_good", 32'(bus.pass), 1);
    dut_is_or = 1'b1;
    sweep(2'b00, 4'b1000, 1, 1'b0);
    chk("mism_or", 32'(bus.mism_cnt), 2);
    chk("pass_or", 32'(bus.pass), 0);
    dut_is_or = 1'b0;
`endif

    // start/mode changes mid-sweep must not relatch the AND mode
    sweep(2'b00, 4'b1000, 1, 1'b1);

    // Reset in the middle of a NAND sweep
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = 2'b11;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_vec", 32'(bus.vec), 2);
    chk("mid_ones", 32'(bus.ones_cnt), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_vec", 32'(bus.vec), 0);
    chk("mrst_vec_valid", 32'(bus.vec_valid), 0);
    chk("mrst_exp", 32'(bus.exp), 0);
    chk("mrst_busy", 32'(bus.busy), 0);
    chk("mrst_done", 32'(bus.done), 0);
    chk("mrst_ones", 32'(bus.ones_cnt), 0);
    @(negedge clk);
    chk("mrst_stays_idle", 32'(bus.busy), 0);
    sweep(2'b11, 4'b0111, 3, 1'b0);

    // N_IN=3, HOLD=1, XOR
    par = 8'h96;
    @(negedge clk);
    bus3.start = 1'b1;
    bus3.mode  = 2'b10;
    @(posedge clk);
    @(negedge clk);
    bus3.start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("n3_vec", 32'(bus3.vec), 32'(c));
      chk("n3_exp", 32'(bus3.exp), 32'(par[c]));
      chk("n3_valid", 32'(bus3.vec_valid), 1);
      @(negedge clk);
    end
    chk("n3_done", 32'(bus3.done), 1);
    chk("n3_vec_last", 32'(bus3.vec), 7);
    chk("n3_ones", 32'(bus3.ones_cnt), 4);
    @(negedge clk);
    chk("n3_idle", 32'(bus3.busy), 0);

    // start held high: back-to-back OR sweeps
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = 2'b01;
    @(posedge clk);
    ndone = 0;
    for (int c = 0; c < 44; c++) begin
      @(negedge clk);
      if (bus.done) ndone++;
      if (c == 20 || c == 42) chk("b2b_done_slot", 32'(bus.done), 1);
      if (c == 20) chk("b2b_ones", 32'(bus.ones_cnt), 3);
      if (c == 21) begin
        chk("b2b_idle_busy", 32'(bus.busy), 0);
        chk("b2b_idle_done", 32'(bus.done), 0);
      end
      if (c == 22) begin
        chk("b2b_restart_vec", 32'(bus.vec), 0);
        chk("b2b_restart_valid", 32'(bus.vec_valid), 1);
        chk("b2b_restart_ones", 32'(bus.ones_cnt), 0);
      end
    end
    chk("b2b_done_count", 32'(ndone), 2);
    bus.start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
